// File: rtl/layer_write_back.sv
// layer_write_back: serialises a latched 16-lane result vector into one feature-map bank,
// one byte per cycle at consecutive (wrapping) addresses, with zero-bubble back-to-back starts.
module layer_write_back #(
    parameter int ADDR_W   = 14,
    parameter int NUM_RAMS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_write_back,
    input  logic [7:0]          u0,
    input  logic [7:0]          u1,
    input  logic [7:0]          u2,
    input  logic [7:0]          u3,
    input  logic [7:0]          u4,
    input  logic [7:0]          u5,
    input  logic [7:0]          u6,
    input  logic [7:0]          u7,
    input  logic [7:0]          u8,
    input  logic [7:0]          u9,
    input  logic [7:0]          u10,
    input  logic [7:0]          u11,
    input  logic [7:0]          u12,
    input  logic [7:0]          u13,
    input  logic [7:0]          u14,
    input  logic [7:0]          u15,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [2:0]          ram_num,
    input  logic [4:0]          num_valid,
    output logic                busy,
    output logic [NUM_RAMS-1:0] wr_en,
    output logic [ADDR_W-1:0]   ram_store_addr,
    output logic [7:0]          ram_store_data,
    output logic                stop_write_back,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;
    state_t              r_state, w_state;
    logic [7:0]          r_lane [16];
    logic [7:0]          w_u [16];
    logic [ADDR_W-1:0]   r_base, r_addr, w_addr;
    logic [7:0]          r_data, w_data;
    logic [NUM_RAMS-1:0] r_wr_en, w_wr_en, w_onehot;
    logic [4:0]          r_cnt, w_cnt;
    logic [3:0]          r_idx, w_idx, w_nidx;
    logic                r_busy, w_busy, r_stop, w_stop, r_err, w_err;
    logic                w_accept, w_legal;

    assign w_u      = '{u0, u1, u2, u3, u4, u5, u6, u7, u8, u9, u10, u11, u12, u13, u14, u15};
    assign w_cnt    = (num_valid > 5'd16) ? 5'd16 : num_valid;
    assign w_legal  = 32'(ram_num) < NUM_RAMS;
    assign w_onehot = w_legal ? NUM_RAMS'(1) << ram_num : '0;
    // The stop cycle doubles as an acceptance window so streams run without bubbles.
    assign w_accept = start_write_back && (!r_busy || r_stop);
    assign w_nidx   = r_idx + 4'd1;

    always_comb begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_wr_en = '0;
        w_stop  = 1'b0;
        w_addr  = r_addr;
        w_data  = r_data;
        w_idx   = r_idx;
        w_err   = r_err || (start_write_back && !w_accept) || (w_accept && !w_legal);
        if (w_accept) begin
            w_busy  = 1'b1;
            w_idx   = 4'd0;
            w_state = (w_cnt == 5'd0) ? FLUSH : WRITE;
            w_stop  = w_cnt <= 5'd1;
            w_wr_en = (w_cnt == 5'd0) ? '0 : w_onehot;
            w_addr  = (w_cnt == 5'd0) ? r_addr : base_addr;
            w_data  = (w_cnt == 5'd0) ? r_data : u0;
        end else if (r_state == WRITE && !r_stop) begin
            w_state = WRITE;
            w_busy  = 1'b1;
            w_idx   = w_nidx;
            w_wr_en = r_wr_en;
            w_addr  = r_base + ADDR_W'(w_nidx);
            w_data  = r_lane[w_nidx];
            w_stop  = ({1'b0, w_nidx} + 5'd1) == r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_wr_en <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_stop  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state;
            r_busy  <= w_busy;
            r_wr_en <= w_wr_en;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_stop  <= w_stop;
            r_err   <= w_err;
            r_idx   <= w_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lane <= w_u;
            r_base <= base_addr;
            r_cnt  <= w_cnt;
        end
    end

    assign busy            = r_busy;
    assign wr_en           = r_wr_en;
    assign ram_store_addr  = r_addr;
    assign ram_store_data  = r_data;
    assign stop_write_back = r_stop;
    assign err             = r_err;
endmodule
